scarv_cop_rng_ctrl: RTL

Sequencing controller for the coprocessor random number generator. It owns the 32-bit LFSR state, accepts the RNG instruction subclasses (seed, sample, test) over the coprocessor `ivalid`/`idone` handshake, and runs background refill of a one-word output buffer. It produces the writeback byte enable and data that the coprocessor register file consumes. It sits between instruction decode and the GPR writeback mux, in place of the stub RNG block.

---
 rtl/scarv_cop_rng_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/scarv_cop_rng_ctrl.sv
// scarv_cop_rng_ctrl: RNG coprocessor sequencing controller with LFSR and one-word refill buffer.
// Ports:
//   g_clk, g_reset       clock, synchronous active-high reset
//   rng_ivalid           instruction valid, held until rng_idone
//   rng_rs1              seed material (sampled at acceptance)
//   id_subclass          0 SEED, 1 SAMP, 2 TEST, others unrecognised
//   rng_idone            one-cycle registered completion pulse
//   rng_cpr_rd_ben       writeback byte enable, zero unless rng_idone
//   rng_cpr_rd_wdata     writeback data, zero unless rng_idone
module scarv_cop_rng_ctrl #(
    parameter int unsigned MIX_STEPS   = 32,
    parameter logic [31:0] POLY        = 32'h8020_0003,
    parameter logic [31:0] RESET_STATE = 32'h0000_0001
) (
    input  logic        g_clk,
    input  logic        g_reset,
    input  logic        rng_ivalid,
    input  logic [31:0] rng_rs1,
    input  logic [3:0]  id_subclass,
    output logic        rng_idone,
    output logic [3:0]  rng_cpr_rd_ben,
    output logic [31:0] rng_cpr_rd_wdata
);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    localparam logic [3:0] SUB_SEED = 4'd0;
    localparam logic [3:0] SUB_SAMP = 4'd1;
    localparam logic [3:0] SUB_TEST = 4'd2;
    state_t      state_q, state_d;
    logic [31:0] lfsr_q, lfsr_d, buf_q, buf_d, wdata_q, wdata_d, seed;
    logic [7:0]  fill_cnt_q, fill_cnt_d;
    logic [3:0]  ben_q, ben_d;
    logic        buf_valid_q, buf_valid_d, seeded_q, seeded_d, fill_busy_q, fill_busy_d, start;
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? (s >> 1) ^ POLY : s >> 1;
    endfunction
    always_comb begin
        state_d     = state_q;
        lfsr_d      = lfsr_q;
        buf_d       = buf_q;
        buf_valid_d = buf_valid_q;
        seeded_d    = seeded_q;
        fill_cnt_d  = fill_cnt_q;
        fill_busy_d = fill_busy_q;
        ben_d       = 4'h0;
        wdata_d     = 32'h0;
        start       = 1'b0;
        seed        = lfsr_q ^ rng_rs1;
        // Background refill runs regardless of the handshake state.
        if (fill_busy_q) begin
            lfsr_d     = lfsr_step(lfsr_q);
            fill_cnt_d = fill_cnt_q - 8'd1;
            if (fill_cnt_q == 8'd0) begin
                buf_d       = lfsr_d;
                buf_valid_d = 1'b1;
                fill_busy_d = 1'b0;
            end
        end
        case (state_q)
            IDLE: if (rng_ivalid) begin
                state_d = RESP;
                case (id_subclass)
                    SUB_SEED: begin
                        // An all-zero LFSR would lock up, so fall back to the reset value.
                        lfsr_d   = (seed == 32'h0) ? RESET_STATE : seed;
                        seeded_d = 1'b1;
                        start    = 1'b1;
                    end
                    SUB_SAMP: begin
                        ben_d = 4'hF;
                        if (seeded_q && buf_valid_q) begin
                            wdata_d = buf_q;
                            start   = 1'b1;
                        end else if (seeded_q) begin
                            state_d = WAIT;
                            ben_d   = 4'h0;
                        end
                    end
                    SUB_TEST: begin
                        ben_d   = 4'hF;
                        wdata_d = {29'b0, fill_busy_q, buf_valid_q, seeded_q};
                    end
                    default: ;
                endcase
            end
            WAIT: if (buf_valid_q) begin
                state_d = RESP;
                ben_d   = 4'hF;
                wdata_d = buf_q;
                start   = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        // Starting a refill overrides any step in flight (a SEED restarts it).
        if (start) begin
            fill_busy_d = 1'b1;
            fill_cnt_d  = 8'(MIX_STEPS - 1);
            buf_valid_d = 1'b0;
        end
    end
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q     <= IDLE;
            lfsr_q      <= RESET_STATE;
            buf_q       <= 32'h0;
            buf_valid_q <= 1'b0;
            seeded_q    <= 1'b0;
            fill_cnt_q  <= 8'h0;
            fill_busy_q <= 1'b0;
            ben_q       <= 4'h0;
            wdata_q     <= 32'h0;
        end else begin
            state_q     <= state_d;
            lfsr_q      <= lfsr_d;
            buf_q       <= buf_d;
            buf_valid_q <= buf_valid_d;
            seeded_q    <= seeded_d;
            fill_cnt_q  <= fill_cnt_d;
            fill_busy_q <= fill_busy_d;
            ben_q       <= ben_d;
            wdata_q     <= wdata_d;
        end
    end
    assign rng_idone        = (state_q == RESP);
    assign rng_cpr_rd_ben   = ben_q;
    assign rng_cpr_rd_wdata = wdata_q;
endmodule
